uart_frame_scheduler: RTL

//   Round-robin scheduler that shares the single byte-wide uart_tx transmitter among N_REQ word producers
//   (e.g. random32 output, ring-oscillator counters, status word).

---
 rtl/uart_frame_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: round-robin arbiter that frames 32-bit words from N_REQ producers
// as {4'hA, id} header plus BYTES payload bytes (LSB first) onto one byte-wide uart_tx.
module uart_frame_scheduler #(
    parameter int N_REQ = 3,
    parameter int BYTES = 4,
    parameter int GUARD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 uart_tx_busy,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    output logic [3:0]           grant_id,
    output logic                 frame_active
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, ISSUE = 2'd2, GUARD_WAIT = 2'd3;
    localparam int GW = $clog2(GUARD + 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic [31:0]      word_q, word_d, shifted;
    logic [3:0]       last_q, last_d, grant_q, grant_d, pick;
    logic [N_REQ-1:0] ready_q, ready_d, rot;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d, active_q, active_d;
    int               c;

    // Walk candidates from farthest to nearest so the nearest valid id after last grant wins.
    always_comb begin
        pick = '0;
        c = 0;
        rot = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = (int'(last_q) + 1 + k) % N_REQ;
            rot = req_valid >> c;
            if (rot[0]) pick = 4'(c);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        guard_d = guard_q;
        word_d = word_q;
        last_d = last_q;
        grant_d = grant_q;
        ready_d = '0;
        en_d = 1'b0;
        active_d = active_q;
        data_d = data_q;
        shifted = word_q >> {idx_q - 3'd1, 3'b000};
        case (state_q)
            IDLE: if (|req_valid) begin
                word_d = 32'(req_data >> (32 * pick));
                grant_d = pick;
                last_d = pick;
                idx_d = '0;
                active_d = 1'b1;
                ready_d = N_REQ'(1) << pick;
                state_d = LOAD;
            end
            LOAD: begin
                data_d = (idx_q == 3'd0) ? {4'hA, grant_q} : shifted[7:0];
                state_d = ISSUE;
            end
            ISSUE: if (!uart_tx_busy) begin
                en_d = 1'b1;
                guard_d = GW'(GUARD);
                state_d = GUARD_WAIT;
            end
            GUARD_WAIT: begin
                guard_d = guard_q - GW'(1);
                if (guard_q == GW'(1)) begin
                    if (idx_q == 3'(BYTES)) begin
                        active_d = 1'b0;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            guard_q <= '0;
            word_q <= '0;
            last_q <= 4'(N_REQ - 1);
            grant_q <= '0;
            ready_q <= '0;
            en_q <= 1'b0;
            active_q <= 1'b0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            guard_q <= guard_d;
            word_q <= word_d;
            last_q <= last_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            en_q <= en_d;
            active_q <= active_d;
            data_q <= data_d;
        end
    end

    assign req_ready = ready_q;
    assign uart_tx_en = en_q;
    assign uart_tx_data = data_q;
    assign grant_id = grant_q;
    assign frame_active = active_q;
endmodule
